// File: rtl/axi_addr_fifo.sv
// AXI4 address-channel request buffer (ID/ADDR/LEN/SIZE/BURST) with occupancy, almost-full and flush.
// Define AXI_ADDR_FIFO_BYPASS_EN for a zero-latency pass-through path when the buffer is empty.
module axi_addr_fifo #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [ID_WIDTH-1:0]        s_id,
  input  logic [ADDR_WIDTH-1:0]      s_addr,
  input  logic [LEN_WIDTH-1:0]       s_len,
  input  logic [SIZE_WIDTH-1:0]      s_size,
  input  logic [1:0]                 s_burst,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [ID_WIDTH-1:0]        m_id,
  output logic [ADDR_WIDTH-1:0]      m_addr,
  output logic [LEN_WIDTH-1:0]       m_len,
  output logic [SIZE_WIDTH-1:0]      m_size,
  output logic [1:0]                 m_burst,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LEVEL);

  logic [ID_WIDTH-1:0]   mem_id    [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
  logic [LEN_WIDTH-1:0]  mem_len   [DEPTH];
  logic [SIZE_WIDTH-1:0] mem_size  [DEPTH];
  logic [1:0]            mem_burst [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic empty, full, push, bypass, pass_through, wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  assign s_ready = ~full & ARESETn;
  assign push    = s_valid & s_ready;

`ifdef AXI_ADDR_FIFO_BYPASS_EN
  // Empty buffer forwards the upstream beat combinationally; gated so reset still shows m_valid=0.
  assign bypass = empty & s_valid & ARESETn;
`else
  assign bypass = 1'b0;
`endif

  assign pass_through = bypass & m_ready;
  assign wr_en        = push & ~pass_through;
  assign rd_en        = ~empty & m_ready;

  assign m_valid     = ~empty | bypass;
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_AFULL);

  always_comb begin
    m_id    = mem_id[rd_ptr];
    m_addr  = mem_addr[rd_ptr];
    m_len   = mem_len[rd_ptr];
    m_size  = mem_size[rd_ptr];
    m_burst = mem_burst[rd_ptr];
    if (bypass) begin
      m_id    = s_id;
      m_addr  = s_addr;
      m_len   = s_len;
      m_size  = s_size;
      m_burst = s_burst;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_id[i]    <= '0;
        mem_addr[i]  <= '0;
        mem_len[i]   <= '0;
        mem_size[i]  <= '0;
        mem_burst[i] <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is cleared.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_id[wr_ptr]    <= s_id;
        mem_addr[wr_ptr]  <= s_addr;
        mem_len[wr_ptr]   <= s_len;
        mem_size[wr_ptr]  <= s_size;
        mem_burst[wr_ptr] <= s_burst;
        wr_ptr            <= ptr_next(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_addr_fifo.sv
// Scoreboard bench for axi_addr_fifo: DEPTH=4 instance for most scenarios, DEPTH=3 for pointer wrap.
// Bypass expectations follow AXI_ADDR_FIFO_BYPASS_EN.
module tb_axi_addr_fifo;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  logic        sv, fl, mr, srdy, mv, af;
  logic [3:0]  sid, mid;
  logic [31:0] saddr, maddr;
  logic [7:0]  slen, mlen;
  logic [2:0]  ssize, msize, cnt;
  logic [1:0]  sburst, mburst;

  logic        sv3, fl3, mr3, srdy3, mv3, af3;
  logic [3:0]  sid3, mid3;
  logic [31:0] saddr3, maddr3;
  logic [7:0]  slen3, mlen3;
  logic [2:0]  ssize3, msize3;
  logic [1:0]  sburst3, mburst3, cnt3;

  int checks = 0;
  int failures = 0;
  logic [35:0] sb_q[$];
  logic [31:0] sb3_q[$];
  logic [35:0] exp_e;

  axi_addr_fifo #(.DEPTH(4)) dut4 (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush(fl),
    .s_valid(sv), .s_ready(srdy), .s_id(sid), .s_addr(saddr), .s_len(slen),
    .s_size(ssize), .s_burst(sburst),
    .m_valid(mv), .m_ready(mr), .m_id(mid), .m_addr(maddr), .m_len(mlen),
    .m_size(msize), .m_burst(mburst), .count(cnt), .almost_full(af)
  );

  axi_addr_fifo #(.DEPTH(3)) dut3 (
    .ACLK(ACLK), .ARESETn(ARESETn), .flush(fl3),
    .s_valid(sv3), .s_ready(srdy3), .s_id(sid3), .s_addr(saddr3), .s_len(slen3),
    .s_size(ssize3), .s_burst(sburst3),
    .m_valid(mv3), .m_ready(mr3), .m_id(mid3), .m_addr(maddr3), .m_len(mlen3),
    .m_size(msize3), .m_burst(mburst3), .count(cnt3), .almost_full(af3)
  );

  task automatic drv(input logic v, input logic [3:0] id, input logic [31:0] a,
                     input logic r, input logic f);
    sv = v; sid = id; saddr = a; slen = {4'h0, id}; ssize = id[2:0]; sburst = 2'b01;
    mr = r; fl = f;
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    drv(1'b1, 4'h5, 32'h55, 1'b0, 1'b0);
    #1;
    checks++; if (srdy !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", srdy); end
    tick();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (mv !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", mv); end
    checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    checks++; if (af !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", af); end
    checks++; if (mid !== 4'h0 || maddr !== 32'h0 || mlen !== 8'h0) begin
      failures++; $display("FAIL reset_payload got id=%h addr=%h len=%h exp=0", mid, maddr, mlen);
    end
    tick();
    ARESETn = 1'b1;
    #1;
    checks++; if (srdy !== 1'b1) begin failures++; $display("FAIL reset_release_s_ready got=%b exp=1", srdy); end
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 4; k++) begin
      drv(1'b1, 4'(k), 32'h1000 + 32'(k), 1'b0, 1'b0);
      #1;
      checks++; if (srdy !== 1'b1) begin failures++; $display("FAIL fill_s_ready k=%0d got=%b exp=1", k, srdy); end
      if (srdy) sb_q.push_back({4'(k), 32'h1000 + 32'(k)});
      tick();
      checks++; if (cnt !== 3'(k)) begin failures++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, cnt, k); end
      checks++; if (af !== (k >= 3)) begin failures++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, af, (k >= 3)); end
      checks++; if (mv !== 1'b1) begin failures++; $display("FAIL fill_m_valid k=%0d got=%b exp=1", k, mv); end
    end
    drv(1'b1, 4'hF, 32'hFFFF, 1'b0, 1'b0);
    #1;
    checks++; if (srdy !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%b exp=0", srdy); end
    tick();
    checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL full_hold_count got=%0d exp=4", cnt); end
    for (int k = 1; k <= 4; k++) begin
      drv(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++;
      if (sb_q.size() == 0) begin failures++; $display("FAIL drain_sb_empty k=%0d got=m_valid %b exp=none", k, mv); end
      else begin
        exp_e = sb_q.pop_front();
        if (mv !== 1'b1 || mid !== exp_e[35:32] || maddr !== exp_e[31:0] || mlen !== {4'h0, exp_e[35:32]} || mburst !== 2'b01) begin
          failures++;
          $display("FAIL drain_head k=%0d got v=%b id=%h addr=%h len=%h exp v=1 id=%h addr=%h", k, mv, mid, maddr, mlen, exp_e[35:32], exp_e[31:0]);
        end
      end
      tick();
    end
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (mv !== 1'b0 || cnt !== 3'd0) begin failures++; $display("FAIL drained got v=%b cnt=%0d exp v=0 cnt=0", mv, cnt); end
  endtask

  task automatic test_wrap();
    int pushes = 0;
    int pops = 0;
    for (int k = 0; k < 10 + 12; k++) begin
      sv3 = (k < 10); sid3 = 4'(k); saddr3 = 32'h100 + 32'(4 * k); slen3 = 8'h0;
      ssize3 = 3'h2; sburst3 = 2'b01; mr3 = 1'b1; fl3 = 1'b0;
      #1;
      if (sv3 && srdy3) begin sb3_q.push_back(saddr3); pushes++; end
      if (mv3) begin
        checks++;
        if (sb3_q.size() == 0) begin failures++; $display("FAIL wrap_unexpected got addr=%h exp=none", maddr3); end
        else begin
          exp_e[31:0] = sb3_q.pop_front();
          if (maddr3 !== exp_e[31:0]) begin failures++; $display("FAIL wrap_order got=%h exp=%h", maddr3, exp_e[31:0]); end
        end
        pops++;
      end
      tick();
    end
    sv3 = 1'b0; mr3 = 1'b0;
    #1;
    checks++; if (pushes != 10) begin failures++; $display("FAIL wrap_pushes got=%0d exp=10", pushes); end
    checks++; if (pops != 10 || cnt3 !== 2'd0) begin failures++; $display("FAIL wrap_pops got=%0d cnt=%0d exp=10 cnt=0", pops, cnt3); end
  endtask

  task automatic test_flush();
    for (int k = 1; k <= 3; k++) begin
      drv(1'b1, 4'(k + 4), 32'h2000 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    checks++; if (cnt !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", cnt); end
    drv(1'b1, 4'h7, 32'h2777, 1'b1, 1'b1);
    tick();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (cnt !== 3'd0 || mv !== 1'b0 || srdy !== 1'b1) begin
      failures++; $display("FAIL flush_state got cnt=%0d v=%b rdy=%b exp cnt=0 v=0 rdy=1", cnt, mv, srdy);
    end
    drv(1'b1, 4'h8, 32'h2888, 1'b0, 1'b0);
    tick();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (mv !== 1'b1 || mid !== 4'h8 || maddr !== 32'h2888 || cnt !== 3'd1) begin
      failures++; $display("FAIL flush_next_head got v=%b id=%h addr=%h cnt=%0d exp v=1 id=8 addr=2888 cnt=1", mv, mid, maddr, cnt);
    end
    drv(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_full_pop();
    for (int k = 1; k <= 4; k++) begin
      drv(1'b1, 4'(k + 8), 32'h3000 + 32'(k), 1'b0, 1'b0);
      #1;
      if (srdy) sb_q.push_back({4'(k + 8), 32'h3000 + 32'(k)});
      tick();
    end
    drv(1'b1, 4'hD, 32'h3DDD, 1'b1, 1'b0);
    #1;
    checks++; if (srdy !== 1'b0) begin failures++; $display("FAIL fullpop_s_ready got=%b exp=0", srdy); end
    checks++;
    if (sb_q.size() == 0) begin failures++; $display("FAIL fullpop_sb_empty got=%0d exp=4", cnt); end
    else begin
      exp_e = sb_q.pop_front();
      if (mv !== 1'b1 || mid !== exp_e[35:32]) begin failures++; $display("FAIL fullpop_head got v=%b id=%h exp v=1 id=%h", mv, mid, exp_e[35:32]); end
    end
    tick();
    checks++; if (cnt !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d exp=3", cnt); end
    drv(1'b1, 4'hD, 32'h3DDD, 1'b0, 1'b0);
    #1;
    checks++; if (srdy !== 1'b1) begin failures++; $display("FAIL fullpop_retry_ready got=%b exp=1", srdy); end
    if (srdy) sb_q.push_back({4'hD, 32'h3DDD});
    tick();
    checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL fullpop_retry_count got=%0d exp=4", cnt); end
    for (int k = 0; k < 2; k++) begin
      drv(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
      #1;
      checks++;
      if (sb_q.size() == 0) begin failures++; $display("FAIL fullpop_drain_empty got v=%b exp=entry", mv); end
      else begin
        exp_e = sb_q.pop_front();
        if (mv !== 1'b1 || maddr !== exp_e[31:0]) begin failures++; $display("FAIL fullpop_drain got v=%b addr=%h exp=%h", mv, maddr, exp_e[31:0]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (cnt !== 3'd2) begin failures++; $display("FAIL rstmid_pre_count got=%0d exp=2", cnt); end
    ARESETn = 1'b0;
    drv(1'b1, 4'h6, 32'h6666, 1'b1, 1'b0);
    #1;
    checks++; if (srdy !== 1'b0) begin failures++; $display("FAIL rstmid_s_ready got=%b exp=0", srdy); end
    tick();
    checks++; if (mv !== 1'b0 || cnt !== 3'd0 || mid !== 4'h0 || maddr !== 32'h0 || srdy !== 1'b0) begin
      failures++; $display("FAIL rstmid_first_edge got v=%b cnt=%0d id=%h addr=%h rdy=%b exp all 0", mv, cnt, mid, maddr, srdy);
    end
    tick();
    ARESETn = 1'b1;
    sb_q.delete();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (mv !== 1'b0 || cnt !== 3'd0 || srdy !== 1'b1) begin
      failures++; $display("FAIL rstmid_after got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=1", mv, cnt, srdy);
    end
  endtask

  task automatic test_bypass();
    drv(1'b1, 4'h3, 32'hDEAD_BEE0, 1'b1, 1'b0);
    #1;
`ifdef AXI_ADDR_FIFO_BYPASS_EN
    checks++; if (mv !== 1'b1 || maddr !== 32'hDEAD_BEE0 || mid !== 4'h3) begin
      failures++; $display("FAIL bypass_same_cycle got v=%b addr=%h id=%h exp v=1 addr=deadbee0 id=3", mv, maddr, mid);
    end
    tick();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (cnt !== 3'd0 || mv !== 1'b0) begin failures++; $display("FAIL bypass_count got cnt=%0d v=%b exp cnt=0 v=0", cnt, mv); end
    drv(1'b1, 4'h4, 32'h4444, 1'b0, 1'b0);
    tick();
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (cnt !== 3'd1 || mid !== 4'h4) begin failures++; $display("FAIL bypass_stall_store got cnt=%0d id=%h exp cnt=1 id=4", cnt, mid); end
    drv(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    tick();
`else
    checks++; if (mv !== 1'b0) begin failures++; $display("FAIL nobypass_same_cycle got v=%b exp=0", mv); end
    tick();
    drv(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (mv !== 1'b1 || maddr !== 32'hDEAD_BEE0 || cnt !== 3'd1) begin
      failures++; $display("FAIL nobypass_next_cycle got v=%b addr=%h cnt=%0d exp v=1 addr=deadbee0 cnt=1", mv, maddr, cnt);
    end
    tick();
`endif
    drv(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (cnt !== 3'd0 || mv !== 1'b0) begin failures++; $display("FAIL bypass_end got cnt=%0d v=%b exp cnt=0 v=0", cnt, mv); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sv3 = 1'b0; mr3 = 1'b0; fl3 = 1'b0; sid3 = '0; saddr3 = '0; slen3 = '0; ssize3 = '0; sburst3 = '0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_full_pop();
    test_reset_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_addr_fifo.md
# axi_addr_fifo

Parametrised AXI4 address-channel request buffer, used on both AW and AR paths between the crossbar slave ports and the arbiter. It stores complete address beats (ID, ADDR, LEN, SIZE, BURST) in arrival order, behind valid/ready handshakes on both sides. All DEPTH slots are usable, including non-power-of-2 depths. It exposes occupancy, an almost-full flag and a synchronous flush, and an optional zero-latency bypass.

## Interface
- ID_WIDTH, 4, transaction ID width
- ADDR_WIDTH, 32, address width
- LEN_WIDTH, 8, burst length width (AXI4)
- SIZE_WIDTH, 3, burst size width
- DEPTH, 4, number of entries; any integer ≥ 2
- AFULL_LEVEL, DEPTH-1, count at or above which almost_full asserts; legal range 1..DEPTH
- ACLK  in  1  clock; all state updates on the rising edge
- ARESETn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of all entries
- s_valid  in  1  upstream request valid
- s_ready  out  1  space available
- s_id / s_addr / s_len / s_size / s_burst  in  ID_WIDTH / ADDR_WIDTH / LEN_WIDTH / SIZE_WIDTH / 2  upstream payload
- m_valid  out  1  head entry valid
- m_ready  in  1  downstream accepts head
- m_id / m_addr / m_len / m_size / m_burst  out  same widths  head payload
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- almost_full  out  1  count ≥ AFULL_LEVEL

## Operation
- Push: s_valid & s_ready at a rising edge writes the payload at wr_ptr, then increments wr_ptr.
- Pop: m_valid & m_ready at a rising edge increments rd_ptr.
- Pointers are $clog2(DEPTH) bits wide. Each wraps explicitly from DEPTH-1 to 0; there is no reliance on modulo-2^n overflow.
- count is a dedicated register:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push+pop or neither
- Status outputs:
  - s_ready = (count != DEPTH) & ARESETn
  - s_ready does not depend on m_ready. At full, a same-cycle pop does not admit a push.
  - m_valid = (count != 0)
  - m_* driven combinationally from the entry at rd_ptr
- Payload on m_* is don't-care while m_valid=0. The bench must not check it then.
- flush: at the edge, count, wr_ptr and rd_ptr go to 0. Any push or pop in that cycle is discarded. Storage contents are not cleared.
- ARESETn low: pointers and count go to 0 and all storage entries are cleared to 0. The reset priority order is ARESETn > flush > push/pop.
- Reset mid-operation drops all queued requests. The upstream master is held off by s_ready=0 for the duration of reset.

## Timing
- Reset values after the first edge with ARESETn low:
  - m_valid=0, count=0, almost_full=0, m_*=0
  - s_ready=0 while ARESETn is low, 1 from the first cycle it is high
- Latency (macro off): push at edge N → m_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- count and almost_full update on the same edge as the causing push/pop. There is no lookahead.
- No combinational path from m_ready to s_ready, or from s_valid to m_valid (macro off).

## Configuration
- AXI_ADDR_FIFO_BYPASS_EN defined:
  - When count==0 and s_valid=1, m_valid=1 in the same cycle and m_* = s_* combinationally.
  - If m_ready=1 in that cycle, the request passes straight through. No write occurs and count stays 0.
  - If m_ready=0, the request is stored normally.
  - s_ready is unchanged.
- AXI_ADDR_FIFO_BYPASS_EN undefined: no combinational s→m path; minimum latency is 1 cycle.

## Test plan
- Reset/fill/drain, DEPTH=4: reset, then push IDs 1,2,3,4 with m_ready=0.
  - count=4, s_ready=0, almost_full=1 from count=3.
  - Then m_ready=1: outputs m_id 1,2,3,4 in order, m_valid=0 after the 4th pop.
- Non-power-of-2 wrap, DEPTH=3: stream 10 pushes with a pop every cycle, addresses 0x100+4k.
  - Addresses emerge in order with no loss.
  - Pointers wrap 2→0.
- Full with simultaneous pop: fill to 4, then s_valid=1 and m_ready=1 for one cycle.
  - The pop occurs, the push is rejected (s_ready was 0), count=3.
  - The next cycle accepts the push.
- Flush: 3 entries queued; flush=1 together with s_valid=1 and m_ready=1.
  - Next cycle: count=0, m_valid=0, s_ready=1.
  - The following push appears at the head.
- Reset mid-operation: 2 entries queued; ARESETn=0 for 2 cycles.
  - s_ready=0 during reset, count=0 and m_valid=0 afterwards.
  - m_*=0 after the first reset edge.
- Bypass, macro defined: empty FIFO, s_valid=1, s_addr=0xDEAD_BEE0, m_ready=1.
  - m_valid=1 and m_addr=0xDEAD_BEE0 in the same cycle; count stays 0.
  - Macro undefined: m_valid rises one cycle later.
